// File: rtl/gnrl_bypbuf.sv
// gnrl_bypbuf: ready-cut valid/ready FIFO buffer; i_rdy depends on registered state only.
// Define GNRL_BYPBUF_BYPASS_EN to enable the zero-latency empty-FIFO bypass path.
module gnrl_bypbuf #(
  parameter int DP = 1,
  parameter int DW = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_vld,
  output logic                    i_rdy,
  input  logic [DW-1:0]           i_dat,
  output logic                    o_vld,
  input  logic                    o_rdy,
  output logic [DW-1:0]           o_dat,
  output logic [$clog2(DP+1)-1:0] o_cnt
);
  localparam int CW = $clog2(DP+1);
  localparam int PW = (DP > 1) ? $clog2(DP) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DP-1);
  localparam logic [CW-1:0] CMAX = CW'(DP);

  logic [DW-1:0] mem_q [DP];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          empty, full;
  logic          in_hs, out_hs;
  logic          byp, wen, ren;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CMAX);
  assign i_rdy  = ~full;
  assign o_cnt  = cnt_q;
  assign in_hs  = i_vld & i_rdy;
  assign out_hs = o_vld & o_rdy;

`ifdef GNRL_BYPBUF_BYPASS_EN
  assign byp   = empty & o_rdy;
  assign o_vld = ~empty | i_vld;
  assign o_dat = empty ? i_dat : mem_q[rd_ptr_q];
`else
  assign byp   = 1'b0;
  assign o_vld = ~empty;
  assign o_dat = mem_q[rd_ptr_q];
`endif

  // A bypassed beat is neither stored nor popped.
  assign wen = in_hs & ~byp;
  assign ren = out_hs & ~empty;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (wen)
      wr_ptr_d = (wr_ptr_q == PMAX) ? '0 : wr_ptr_q + PW'(1);
    if (ren)
      rd_ptr_d = (rd_ptr_q == PMAX) ? '0 : rd_ptr_q + PW'(1);
    unique case ({wen, ren})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wen) mem_q[wr_ptr_q] <= i_dat;
  end

endmodule
